// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU sharing controller:
//   - ALU opcode encodings (must match the ALU instance)
//   - controller FSM state encoding
//   - fixed result reported for a rejected divide-by-zero
//   - helper to detect a divide-by-zero request before it reaches the ALU
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0111;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_SHR = 4'b1001;
    localparam logic [3:0] OP_ADC = 4'b1010;
    localparam logic [3:0] OP_SBC = 4'b1011;
    localparam logic [3:0] OP_ROL = 4'b1100;
    localparam logic [3:0] OP_ROR = 4'b1101;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [15:0] DIV0_RESULT = 16'hFFFF;

    // A divide with a zero divisor never goes to the ALU; it is answered
    // directly with an error response.
    function automatic logic is_div0(input logic [3:0] op, input logic [15:0] b);
        return (op == OP_DIV) && (b == 16'h0000);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Searches the request vector starting
// one position after the last grant (ptr) and wrapping modulo N_REQ.
//   req   in  N_REQ  request bits
//   ptr   in  IW     index of the most recently granted requester
//   en    in  1      arbitration enable; no grant when low
//   grant out N_REQ  one-hot grant (all zero when nothing granted)
//   idx   out IW     encoded index of the granted requester
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx
);

    logic w_found;
    int   w_cand;

    always_comb begin
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        w_cand  = 0;
        // Candidates are visited in priority order ptr+1, ptr+2, ... ptr,
        // so the last winner is considered last.
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = (int'(ptr) + k) % N_REQ;
            if (en && !w_found && req[w_cand]) begin
                w_found        = 1'b1;
                grant[w_cand]  = 1'b1;
                idx            = w_cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// alu_share_ctrl
// Shares one registered ALU between N_REQ requesters. One operation is in
// flight at a time: grant (IDLE) -> drive ALU (ISSUE) -> wait ALU_LAT
// (WAIT) -> hold response until accepted (RESP).
//   CLK, RST                    clock, synchronous active-high reset
//   req_valid/req_ready         per-requester request handshake (one-hot ready)
//   req_a/req_b/req_op/req_cin  packed per-requester operands
//   alu_a/alu_b/alu_op/alu_cin  registered ALU inputs
//   alu_y/alu_cout              ALU result
//   rsp_valid/rsp_ready         response handshake
//   rsp_id/rsp_y/rsp_cout/rsp_err  response payload
// ---------------------------------------------------------------------------
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ALU_LAT = 1,
    parameter int DW      = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*DW-1:0]      req_a,
    input  logic [N_REQ*DW-1:0]      req_b,
    input  logic [N_REQ*4-1:0]       req_op,
    input  logic [N_REQ-1:0]         req_cin,
    output logic [DW-1:0]            alu_a,
    output logic [DW-1:0]            alu_b,
    output logic [3:0]               alu_op,
    output logic                     alu_cin,
    input  logic [DW-1:0]            alu_y,
    input  logic                     alu_cout,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [DW-1:0]            rsp_y,
    output logic                     rsp_cout,
    output logic                     rsp_err
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(ALU_LAT + 1);

    logic [1:0]       r_state;
    logic [IW-1:0]    r_ptr;
    logic [CW-1:0]    r_cnt;

    logic [N_REQ-1:0] w_grant;
    logic [IW-1:0]    w_idx;
    logic             w_any;
    logic             w_arb_en;
    logic [DW-1:0]    w_a;
    logic [DW-1:0]    w_b;
    logic [3:0]       w_op;
    logic             w_cin;

    // No grant while reset is applied, so nothing is transferred that the
    // reset would then throw away.
    assign w_arb_en = (r_state == IDLE) && !RST;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (r_ptr),
        .en    (w_arb_en),
        .grant (w_grant),
        .idx   (w_idx)
    );

    assign req_ready = w_grant;
    assign w_any     = |w_grant;
    assign w_a       = req_a[w_idx*DW +: DW];
    assign w_b       = req_b[w_idx*DW +: DW];
    assign w_op      = req_op[w_idx*4 +: 4];
    assign w_cin     = req_cin[w_idx];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_ptr     <= IW'(N_REQ - 1);
            r_cnt     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            alu_cin   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_y     <= '0;
            rsp_cout  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_ptr  <= w_idx;
                        rsp_id <= w_idx;
                        if (is_div0(w_op, w_b)) begin
                            // ALU inputs deliberately left untouched.
                            rsp_y     <= DIV0_RESULT;
                            rsp_cout  <= 1'b0;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            r_state   <= RESP;
                        end else begin
                            alu_a   <= w_a;
                            alu_b   <= w_b;
                            alu_op  <= w_op;
                            alu_cin <= w_cin;
                            r_state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    r_cnt   <= CW'(ALU_LAT - 1);
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        rsp_y     <= alu_y;
                        rsp_cout  <= alu_cout;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        r_state   <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_share_ctrl
// Two controller instances (ALU_LAT=1 and ALU_LAT=3), each with a behavioural
// registered ALU. Stimulus pushes hand-computed expected responses into a
// queue; a monitor per instance pops and compares on every response handshake.
// ---------------------------------------------------------------------------
module tb_alu_share_ctrl;
    import alu_pkg::*;

    localparam int N  = 4;
    localparam int DW = 16;

    typedef struct {
        int          id;
        logic [15:0] y;
        logic        cout;
        logic        err;
        int          rise;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t q1[$];
    exp_t q3[$];

    // ---------------- instance with ALU_LAT = 1 ----------------
    logic [N-1:0]    req_valid = '0, req_ready, req_cin = '0;
    logic [N*DW-1:0] req_a = '0, req_b = '0;
    logic [N*4-1:0]  req_op = '0;
    logic [DW-1:0]   alu_a, alu_b, alu_y, rsp_y;
    logic [3:0]      alu_op;
    logic            alu_cin, alu_cout, rsp_valid, rsp_cout, rsp_err;
    logic            rsp_ready = 1'b1;
    logic [1:0]      rsp_id;

    alu_share_ctrl #(.N_REQ(N), .ALU_LAT(1), .DW(DW)) dut1 (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_cin(req_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_y(alu_y), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_cout(rsp_cout), .rsp_err(rsp_err)
    );

    // ---------------- instance with ALU_LAT = 3 ----------------
    logic [N-1:0]    req_valid3 = '0, req_ready3, req_cin3 = '0;
    logic [N*DW-1:0] req_a3 = '0, req_b3 = '0;
    logic [N*4-1:0]  req_op3 = '0;
    logic [DW-1:0]   alu_a3, alu_b3, alu_y3, rsp_y3;
    logic [3:0]      alu_op3;
    logic            alu_cin3, alu_cout3, rsp_valid3, rsp_cout3, rsp_err3;
    logic            rsp_ready3 = 1'b1;
    logic [1:0]      rsp_id3;

    alu_share_ctrl #(.N_REQ(N), .ALU_LAT(3), .DW(DW)) dut3 (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a3), .req_b(req_b3), .req_op(req_op3), .req_cin(req_cin3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3), .alu_cin(alu_cin3),
        .alu_y(alu_y3), .alu_cout(alu_cout3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3),
        .rsp_y(rsp_y3), .rsp_cout(rsp_cout3), .rsp_err(rsp_err3)
    );

    // ---------------- behavioural ALUs ----------------
    function automatic logic [16:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] op, input logic cin);
        case (op)
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {1'b0, a} - {1'b0, b};
            OP_AND:  return {1'b0, a & b};
            OP_ADC:  return {1'b0, a} + {1'b0, b} + {16'h0, cin};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    logic [16:0] p1;
    logic [16:0] p3 [3];
    always @(posedge CLK) begin
        p1    <= alu_f(alu_a, alu_b, alu_op, alu_cin);
        p3[0] <= alu_f(alu_a3, alu_b3, alu_op3, alu_cin3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign {alu_cout, alu_y}   = p1;
    assign {alu_cout3, alu_y3} = p3[2];

    // ---------------- checking ----------------
    function automatic void chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end else begin
            $display("[TB] ok   %s = %0h (cycle %0d)", name, got, cyc);
        end
    endfunction

    logic pv1 = 1'b0, pv3 = 1'b0;
    int   rise1 = 0, rise3 = 0;

    always @(negedge CLK) begin
        exp_t e;
        if (!RST) begin
            if (rsp_valid && !pv1) rise1 = cyc;
            if (rsp_valid && rsp_ready) begin
                n_tests++;
                if (q1.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL rsp1_unexpected: got id %0h y %0h, required no response", rsp_id, rsp_y);
                end else begin
                    e = q1.pop_front();
                    chk("rsp1_id", int'(rsp_id), e.id);
                    chk("rsp1_y", int'(rsp_y), int'(e.y));
                    chk("rsp1_cout", int'(rsp_cout), int'(e.cout));
                    chk("rsp1_err", int'(rsp_err), int'(e.err));
                    chk("rsp1_rise_cycle", rise1, e.rise);
                end
            end
        end
        pv1 = rsp_valid && !RST;
    end

    always @(negedge CLK) begin
        exp_t e;
        if (!RST) begin
            if (rsp_valid3 && !pv3) rise3 = cyc;
            if (rsp_valid3 && rsp_ready3) begin
                n_tests++;
                if (q3.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL rsp3_unexpected: got id %0h y %0h, required no response", rsp_id3, rsp_y3);
                end else begin
                    e = q3.pop_front();
                    chk("rsp3_id", int'(rsp_id3), e.id);
                    chk("rsp3_y", int'(rsp_y3), int'(e.y));
                    chk("rsp3_cout", int'(rsp_cout3), int'(e.cout));
                    chk("rsp3_err", int'(rsp_err3), int'(e.err));
                    chk("rsp3_rise_cycle", rise3, e.rise);
                end
            end
        end
        pv3 = rsp_valid3 && !RST;
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] op, input logic cin);
        req_a[id*DW +: DW] = a;
        req_b[id*DW +: DW] = b;
        req_op[id*4 +: 4]  = op;
        req_cin[id]        = cin;
    endtask

    // Raise one request, wait (bounded) for its grant, optionally queue the
    // expected response, then drop the request after the accept edge.
    task automatic issue1(input int id, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] op, input bit want_rsp,
                          input logic [15:0] ey, input logic ecout, input logic eerr,
                          input int lat, output int t);
        exp_t e;
        bit   got;
        set_req(id, a, b, op, 1'b0);
        req_valid[id] = 1'b1;
        got = 1'b0;
        t   = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge CLK);
            if (req_ready != '0) got = 1'b1;
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("[TB] FAIL grant_timeout: req %0d got no grant within 50 cycles", id);
        end else begin
            t = cyc;
            chk("grant_onehot", int'(req_ready), 1 << id);
            if (want_rsp) begin
                e.id = id; e.y = ey; e.cout = ecout; e.err = eerr; e.rise = t + lat;
                q1.push_back(e);
            end
        end
        @(posedge CLK); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (q1.size() != 0 || q3.size() != 0); i++) @(negedge CLK);
        n_tests++;
        if (q1.size() != 0 || q3.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drain_timeout: got %0d/%0d pending responses, required 0", q1.size(), q3.size());
        end
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int   t, tprev, g, h;
        bit   got;
        exp_t e;

        // Reset state
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_alu_a", int'(alu_a), 0);
        chk("rst_alu_op", int'(alu_op), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_y", int'(rsp_y), 0);
        chk("rst_rsp_err", int'(rsp_err), 0);
        @(posedge CLK); #1;
        RST = 1'b0;

        // 1. Single request: 3 + 4 = 7, response 3 cycles after accept
        issue1(0, 16'h0003, 16'h0004, OP_ADD, 1'b1, 16'h0007, 1'b0, 1'b0, 3, t);
        drain();

        // 2. Round-robin fairness from a fresh reset: 0,1,2,3,0, 4 cycles apart
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 16'(i + 1), 16'h0010, OP_ADD, 1'b0);
        req_valid = 4'hF;
        tprev = 0;
        for (int k = 0; k < 5; k++) begin
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge CLK);
                if (req_ready != '0) got = 1'b1;
            end
            if (!got) begin
                n_tests++; n_fail++;
                $display("[TB] FAIL rr_timeout: no grant %0d within 20 cycles", k);
            end else begin
                g = 0;
                for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
                chk("rr_grant", int'(req_ready), 1 << (k % N));
                if (k > 0) chk("rr_spacing", cyc - tprev, 4);
                tprev = cyc;
                e.id = g; e.y = 16'(16'h0011 + g); e.cout = 1'b0; e.err = 1'b0; e.rise = cyc + 3;
                q1.push_back(e);
            end
        end
        @(posedge CLK); #1;
        req_valid = '0;
        drain();

        // 3. Divide by zero: immediate error response, ALU inputs untouched
        //    (last ALU operation was req 0: ADD 0x0001, 0x0010)
        issue1(2, 16'h0010, 16'h0000, OP_DIV, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1, t);
        @(negedge CLK);
        chk("div0_valid_next_cycle", int'(rsp_valid), 1);
        chk("div0_alu_a_held", int'(alu_a), 16'h0001);
        chk("div0_alu_b_held", int'(alu_b), 16'h0010);
        chk("div0_alu_op_held", int'(alu_op), int'(OP_ADD));
        drain();

        // 4. Response backpressure with req 1 pending
        rsp_ready = 1'b0;
        set_req(1, 16'h0100, 16'h0200, OP_ADD, 1'b0);
        req_valid[1] = 1'b1;
        issue1(0, 16'h00F0, 16'h0FF0, OP_AND, 1'b1, 16'h00F0, 1'b0, 1'b0, 3, t);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge CLK);
            if (rsp_valid) got = 1'b1;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", int'(rsp_valid), 1);
            chk("bp_rsp_y", int'(rsp_y), 16'h00F0);
            chk("bp_rsp_id", int'(rsp_id), 0);
            chk("bp_req_ready", int'(req_ready), 0);
            if (i < 4) @(negedge CLK);
        end
        @(posedge CLK); #1;
        rsp_ready = 1'b1;
        h = cyc;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge CLK);
            if (req_ready[1]) got = 1'b1;
        end
        chk("bp_grant_cycle", cyc, h + 1);
        e.id = 1; e.y = 16'h0300; e.cout = 1'b0; e.err = 1'b0; e.rise = cyc + 3;
        q1.push_back(e);
        @(posedge CLK); #1;
        req_valid[1] = 1'b0;
        drain();

        // 5. Reset during WAIT: in-flight result discarded, req 0 wins after reset
        issue1(1, 16'h0005, 16'h0005, OP_ADD, 1'b0, 16'h0000, 1'b0, 1'b0, 3, t);
        @(posedge CLK); #1;           // now in WAIT
        RST = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 16'(i + 1), 16'h0010, OP_ADD, 1'b0);
        req_valid = 4'hF;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_mid_rsp_valid", int'(rsp_valid), 0);
        chk("rst_mid_first_grant", int'(req_ready), 1);
        e.id = 0; e.y = 16'h0011; e.cout = 1'b0; e.err = 1'b0; e.rise = cyc + 3;
        q1.push_back(e);
        @(posedge CLK); #1;
        req_valid = '0;
        drain();

        // 6. ALU_LAT = 3: 5 - 7 = 0xFFFE with borrow, response 5 cycles after accept
        req_a3[3*DW +: DW] = 16'h0005;
        req_b3[3*DW +: DW] = 16'h0007;
        req_op3[3*4 +: 4]  = OP_SUB;
        req_valid3[3]      = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge CLK);
            if (req_ready3 != '0) got = 1'b1;
        end
        chk("lat3_grant", int'(req_ready3), 8);
        e.id = 3; e.y = 16'hFFFE; e.cout = 1'b1; e.err = 1'b0; e.rise = cyc + 5;
        q3.push_back(e);
        @(posedge CLK); #1;
        req_valid3 = '0;
        drain();

        repeat (10) @(posedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
